// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-boundary register: DEPTH stages of {valid, ctrl, data_a, data_b, rd}
// with stall (hold), flush (bubble insertion) and a saturating count of output bubbles.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 2,
  parameter int RD_W   = 5,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              cnt_clr_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_a_i,
  input  logic [DATA_W-1:0] data_b_i,
  input  logic [RD_W-1:0]   rd_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_a_o,
  output logic [DATA_W-1:0] data_b_o,
  output logic [RD_W-1:0]   rd_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  generate
    if (DEPTH < 1 || DEPTH > 4) begin : g_depth_chk
      $error("pipe_stage_reg: DEPTH=%0d is outside the legal range 1..4", DEPTH);
    end
  endgenerate

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic              vld_p    [DEPTH];
  logic [CTRL_W-1:0] ctrl_p   [DEPTH];
  logic [DATA_W-1:0] data_a_p [DEPTH];
  logic [DATA_W-1:0] data_b_p [DEPTH];
  logic [RD_W-1:0]   rd_p     [DEPTH];
  logic [CNT_W-1:0]  bubble_cnt;

  // Bubbles never carry RegWrite or a destination: gate them before stage 0.
  logic [CTRL_W-1:0] ctrl_in;
  logic [RD_W-1:0]   rd_in;
  assign ctrl_in = valid_i ? ctrl_i : '0;
  assign rd_in   = valid_i ? rd_i   : '0;

  // Stages 0..DEPTH-1: flush > stall > advance
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        vld_p[k]    <= 1'b0;
        ctrl_p[k]   <= '0;
        data_a_p[k] <= '0;
        data_b_p[k] <= '0;
        rd_p[k]     <= '0;
      end
    end else if (flush_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        vld_p[k]    <= 1'b0;
        ctrl_p[k]   <= '0;
        data_a_p[k] <= '0;
        data_b_p[k] <= '0;
        rd_p[k]     <= '0;
      end
    end else if (!stall_i) begin
      vld_p[0]    <= valid_i;
      ctrl_p[0]   <= ctrl_in;
      data_a_p[0] <= data_a_i;
      data_b_p[0] <= data_b_i;
      rd_p[0]     <= rd_in;
      for (int k = 1; k < DEPTH; k++) begin
        vld_p[k]    <= vld_p[k-1];
        ctrl_p[k]   <= ctrl_p[k-1];
        data_a_p[k] <= data_a_p[k-1];
        data_b_p[k] <= data_b_p[k-1];
        rd_p[k]     <= rd_p[k-1];
      end
    end
  end

  // Valid bit of whatever an advancing edge would move into the output stage.
  logic out_src_vld;
  generate
    if (DEPTH == 1) begin : g_src_in
      assign out_src_vld = valid_i;
    end else begin : g_src_stage
      assign out_src_vld = vld_p[DEPTH-2];
    end
  endgenerate

  logic bubble_edge;
  assign bubble_edge = flush_i | (~stall_i & ~out_src_vld);

  // Bubble counter: clear has priority over the saturating increment
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bubble_cnt <= '0;
    end else if (cnt_clr_i) begin
      bubble_cnt <= '0;
    end else if (bubble_edge) begin
      bubble_cnt <= sat_inc(bubble_cnt);
    end
  end

  assign valid_o      = vld_p[DEPTH-1];
  assign ctrl_o       = ctrl_p[DEPTH-1];
  assign data_a_o     = data_a_p[DEPTH-1];
  assign data_b_o     = data_b_p[DEPTH-1];
  assign rd_o         = rd_p[DEPTH-1];
  assign bubble_cnt_o = bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (DEPTH 1/2/3) share stimulus and are compared
// against a queue-based model, plus a vector table and hand-written corner sequences.
module tb_pipe_stage_reg;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i, stall_i, flush_i, cnt_clr_i;
  logic [1:0]  ctrl_i;
  logic [31:0] data_a_i, data_b_i;
  logic [4:0]  rd_i;

  logic        o_v   [3];
  logic [1:0]  o_c   [3];
  logic [31:0] o_a   [3];
  logic [31:0] o_b   [3];
  logic [4:0]  o_rd  [3];
  logic [2:0]  cnt1;
  logic [15:0] cnt2;
  logic [3:0]  cnt3;
  logic [15:0] got_cnt [3];

  assign got_cnt[0] = {13'b0, cnt1};
  assign got_cnt[1] = cnt2;
  assign got_cnt[2] = {12'b0, cnt3};

  always #5 clk_i = ~clk_i;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(2), .RD_W(5), .DEPTH(1), .CNT_W(3)) u1 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
    .cnt_clr_i(cnt_clr_i), .ctrl_i(ctrl_i), .data_a_i(data_a_i), .data_b_i(data_b_i),
    .rd_i(rd_i), .valid_o(o_v[0]), .ctrl_o(o_c[0]), .data_a_o(o_a[0]), .data_b_o(o_b[0]),
    .rd_o(o_rd[0]), .bubble_cnt_o(cnt1));

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(2), .RD_W(5), .DEPTH(2), .CNT_W(16)) u2 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
    .cnt_clr_i(cnt_clr_i), .ctrl_i(ctrl_i), .data_a_i(data_a_i), .data_b_i(data_b_i),
    .rd_i(rd_i), .valid_o(o_v[1]), .ctrl_o(o_c[1]), .data_a_o(o_a[1]), .data_b_o(o_b[1]),
    .rd_o(o_rd[1]), .bubble_cnt_o(cnt2));

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(2), .RD_W(5), .DEPTH(3), .CNT_W(4)) u3 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
    .cnt_clr_i(cnt_clr_i), .ctrl_i(ctrl_i), .data_a_i(data_a_i), .data_b_i(data_b_i),
    .rd_i(rd_i), .valid_o(o_v[2]), .ctrl_o(o_c[2]), .data_a_o(o_a[2]), .data_b_o(o_b[2]),
    .rd_o(o_rd[2]), .bubble_cnt_o(cnt3));

  typedef struct packed {
    logic        v;
    logic [1:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } rec_t;

  typedef struct {
    logic        v, s, f, clr;
    logic [1:0]  c;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic        ev;
    logic [1:0]  ec;
    logic [31:0] ea, eb;
    logic [4:0]  erd;
    int          ecnt;
  } vec_t;

  // Model: each instance is a queue of DEPTH slot records, output = last element.
  rec_t mq [3][$];
  int   mcnt [3];
  int   depth [3] = '{1, 2, 3};
  int   cmax  [3] = '{7, 65535, 15};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      for (int k = 0; k < depth[i]; k++) mq[i].push_back('0);
      mcnt[i] = 0;
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < 3; i++) begin
      rec_t e;
      e = mq[i][$];
      chk($sformatf("u%0d.valid", i + 1), o_v[i], e.v);
      chk($sformatf("u%0d.ctrl", i + 1), o_c[i], e.c);
      chk($sformatf("u%0d.data_a", i + 1), o_a[i], e.a);
      chk($sformatf("u%0d.data_b", i + 1), o_b[i], e.b);
      chk($sformatf("u%0d.rd", i + 1), o_rd[i], e.rd);
      chk($sformatf("u%0d.bubble_cnt", i + 1), got_cnt[i], mcnt[i]);
    end
  endtask

  // Drive one cycle of inputs, advance the model, clock, then compare.
  task automatic step(input logic v, input logic s, input logic f, input logic clr,
                      input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd);
    rec_t n;
    valid_i = v; stall_i = s; flush_i = f; cnt_clr_i = clr;
    ctrl_i = c; data_a_i = a; data_b_i = b; rd_i = rd;
    n.v  = v;
    n.c  = v ? c : 2'b0;
    n.a  = a;
    n.b  = b;
    n.rd = v ? rd : 5'd0;
    for (int i = 0; i < 3; i++) begin
      logic held;
      held = s && !f;
      if (f) begin
        foreach (mq[i][k]) mq[i][k] = '0;
      end else if (!s) begin
        mq[i].push_front(n);
        void'(mq[i].pop_back());
      end
      if (clr) mcnt[i] = 0;
      else if (!held && !mq[i][$].v && mcnt[i] < cmax[i]) mcnt[i]++;
    end
    @(posedge clk_i);
    #1;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 2'b0, 32'h0, 32'h0, 5'd0);
  endtask

  // Asserts reset away from a clock edge, checks outputs at once, releases on a falling edge.
  task automatic do_reset(input string tag);
    #2;
    rst_i = 1'b0;
    #1;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s.u%0d.valid", tag, i + 1), o_v[i], 0);
      chk($sformatf("%s.u%0d.ctrl", tag, i + 1), o_c[i], 0);
      chk($sformatf("%s.u%0d.data_a", tag, i + 1), o_a[i], 0);
      chk($sformatf("%s.u%0d.data_b", tag, i + 1), o_b[i], 0);
      chk($sformatf("%s.u%0d.rd", tag, i + 1), o_rd[i], 0);
      chk($sformatf("%s.u%0d.cnt", tag, i + 1), got_cnt[i], 0);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [7];
    rec_t ra, rb;
    tbl[0] = '{v:1, s:0, f:0, clr:0, c:2'b01, a:32'hDEAD_BEEF, b:32'h10, rd:9,
               ev:1, ec:2'b01, ea:32'hDEAD_BEEF, eb:32'h10, erd:9, ecnt:0};
    tbl[1] = '{v:0, s:0, f:0, clr:0, c:2'b11, a:32'h1234, b:32'h5678, rd:31,
               ev:0, ec:2'b00, ea:32'h1234, eb:32'h5678, erd:0, ecnt:1};
    tbl[2] = '{v:1, s:0, f:0, clr:0, c:2'b10, a:32'hAAAA, b:32'hBBBB, rd:3,
               ev:1, ec:2'b10, ea:32'hAAAA, eb:32'hBBBB, erd:3, ecnt:1};
    tbl[3] = '{v:1, s:1, f:0, clr:0, c:2'b01, a:32'h1, b:32'h2, rd:4,
               ev:1, ec:2'b10, ea:32'hAAAA, eb:32'hBBBB, erd:3, ecnt:1};
    tbl[4] = '{v:1, s:1, f:1, clr:0, c:2'b11, a:32'h9, b:32'h9, rd:7,
               ev:0, ec:2'b00, ea:32'h0, eb:32'h0, erd:0, ecnt:2};
    tbl[5] = '{v:1, s:0, f:0, clr:1, c:2'b11, a:32'hCAFE, b:32'hF00D, rd:31,
               ev:1, ec:2'b11, ea:32'hCAFE, eb:32'hF00D, erd:31, ecnt:0};
    tbl[6] = '{v:0, s:0, f:0, clr:1, c:2'b11, a:32'h77, b:32'h88, rd:5,
               ev:0, ec:2'b00, ea:32'h77, eb:32'h88, erd:0, ecnt:0};

    rst_i = 1'b0;
    valid_i = 0; stall_i = 0; flush_i = 0; cnt_clr_i = 0;
    ctrl_i = 0; data_a_i = 0; data_b_i = 0; rd_i = 0;
    do_reset("reset");

    for (int t = 0; t < 7; t++) begin
      step(tbl[t].v, tbl[t].s, tbl[t].f, tbl[t].clr, tbl[t].c, tbl[t].a, tbl[t].b, tbl[t].rd);
      chk($sformatf("tbl%0d.valid", t), o_v[0], tbl[t].ev);
      chk($sformatf("tbl%0d.ctrl", t), o_c[0], tbl[t].ec);
      chk($sformatf("tbl%0d.data_a", t), o_a[0], tbl[t].ea);
      chk($sformatf("tbl%0d.data_b", t), o_b[0], tbl[t].eb);
      chk($sformatf("tbl%0d.rd", t), o_rd[0], tbl[t].erd);
      chk($sformatf("tbl%0d.cnt", t), cnt1, tbl[t].ecnt);
    end

    // DEPTH=3 latency: A, B, C on consecutive edges reach the output on edges 3, 4, 5.
    do_reset("lat_reset");
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 32'hA, 32'hA0, 5'd1);
    chk("lat.e1.valid", o_v[2], 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 32'hB, 32'hB0, 5'd2);
    chk("lat.e2.valid", o_v[2], 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 32'hC, 32'hC0, 5'd3);
    chk("lat.e3.A", o_a[2], 32'hA);
    chk("lat.e3.cnt", cnt3, 2);
    idle(1);
    chk("lat.e4.B", o_a[2], 32'hB);
    idle(1);
    chk("lat.e5.C", o_a[2], 32'hC);
    chk("lat.e5.rd", o_rd[2], 3);

    // DEPTH=2 stall hold: A in stage1, B in stage0, stall for 3 edges with changing inputs.
    ra = '{v:1'b1, c:2'b01, a:32'h1111_0000, b:32'h1, rd:5'd10};
    rb = '{v:1'b1, c:2'b11, a:32'h2222_0000, b:32'h2, rd:5'd11};
    step(ra.v, 1'b0, 1'b0, 1'b0, ra.c, ra.a, ra.b, ra.rd);
    step(rb.v, 1'b0, 1'b0, 1'b0, rb.c, rb.a, rb.b, rb.rd);
    chk("stall.pre.A", o_a[1], ra.a);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, $urandom, $urandom, 5'(k + 20));
      chk($sformatf("stall.hold%0d.A", k), o_a[1], ra.a);
      chk($sformatf("stall.hold%0d.rd", k), o_rd[1], ra.rd);
    end
    idle(1);
    chk("stall.release.B", o_a[1], rb.a);
    chk("stall.release.rd", o_rd[1], rb.rd);

    // Flush over stall with every stage holding a real instruction.
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 32'h5000 + k, 32'h6000 + k, 5'd12);
    step(1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 32'hFFFF, 32'hFFFF, 5'd31);
    chk("flush.u3.valid", o_v[2], 0);
    chk("flush.u3.data_a", o_a[2], 0);

    // Saturation on the 3-bit counter, then clear wins over a bubble edge.
    idle(10);
    chk("sat.cnt1", cnt1, 7);
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 32'h0, 32'h0, 5'd31);
    chk("clr.cnt1", cnt1, 0);
    chk("clr.ctrl", o_c[0], 0);

    // Async reset mid-stream.
    for (int k = 0; k < 2; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 32'h7000 + k, 32'h1, 5'd7);
    do_reset("midreset");

    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 19) == 0, 2'($urandom), $urandom, $urandom, 5'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
